// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one multchan_comm message channel between the instruction-fetch (I)
//   and data (D) memory ports. Each request is packed into a message for the
//   remote memory model; the single outstanding read is tracked and its data
//   is returned to the port that issued it.
//
//   Build option: define MEM_ARB_RR_EN for round-robin arbitration between I
//   and D (reset favours D). Undefined: fixed priority, D always wins.
//
// Parameters
//   TIMEOUT  max cycles spent waiting for a read response (0 = never time out)
//   TO_BITS  width of the timeout counter, must hold TIMEOUT
//
// Ports
//   CLK, RST_N                       clock, asynchronous active-low reset
//   i_req/i_addr                     I-port read request
//   i_done/i_rdata                   I-port completion pulse and read data
//   d_req/d_we/d_addr/d_wdata/d_mask D-port request (read or write)
//   d_done/d_rdata                   D-port completion pulse and read data
//   err                              pulse: timeout, bad length, unsolicited response
//   send_flag/send_len/send_data     outgoing message (send_ready = writable)
//   recv_avail/recv_len/recv_data    incoming response, popped by recv_ack pulse
module mem_req_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_BITS = 11
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mask,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        send_flag,
    output logic [4:0]  send_len,
    output logic [71:0] send_data,
    input  logic        send_ready,
    input  logic        recv_avail,
    input  logic [4:0]  recv_len,
    input  logic [71:0] recv_data,
    output logic        recv_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t               state, state_n;
    logic                 cur_d, cur_d_n;     // 1 = transfer belongs to D port
    logic                 cur_we, cur_we_n;
    logic [TO_BITS-1:0]   cnt, cnt_n;
    logic                 i_done_n, d_done_n, err_n, send_flag_n, recv_ack_n;
    logic [31:0]          i_rdata_n, d_rdata_n;
    logic [4:0]           send_len_n;
    logic [71:0]          send_data_n;

    logic                 resp_ok;
    logic                 grant_ok;
    logic                 d_win;
    logic                 rd_finish;
    logic [31:0]          rd_val;
    logic [31:0]          g_addr;

`ifdef MEM_ARB_RR_EN
    logic                 ptr_d, ptr_d_n;     // 1 = D favoured on a tie
`endif

    // Upper response bits carry nothing for a 4-byte read reply.
    logic                 unused_recv;
    assign unused_recv = ^recv_data[71:32];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            cur_d     <= 1'b0;
            cur_we    <= 1'b0;
            cnt       <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            send_flag <= 1'b0;
            recv_ack  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            send_len  <= '0;
            send_data <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_d     <= 1'b1;
`endif
        end else begin
            state     <= state_n;
            cur_d     <= cur_d_n;
            cur_we    <= cur_we_n;
            cnt       <= cnt_n;
            i_done    <= i_done_n;
            d_done    <= d_done_n;
            err       <= err_n;
            send_flag <= send_flag_n;
            recv_ack  <= recv_ack_n;
            i_rdata   <= i_rdata_n;
            d_rdata   <= d_rdata_n;
            send_len  <= send_len_n;
            send_data <= send_data_n;
`ifdef MEM_ARB_RR_EN
            ptr_d     <= ptr_d_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cur_d_n     = cur_d;
        cur_we_n    = cur_we;
        cnt_n       = cnt;
        i_done_n    = 1'b0;
        d_done_n    = 1'b0;
        err_n       = 1'b0;
        send_flag_n = 1'b0;
        recv_ack_n  = 1'b0;
        i_rdata_n   = i_rdata;
        d_rdata_n   = d_rdata;
        send_len_n  = send_len;
        send_data_n = send_data;
        rd_finish   = 1'b0;
        rd_val      = '0;
`ifdef MEM_ARB_RR_EN
        ptr_d_n     = ptr_d;
        d_win       = d_req & (~i_req | ptr_d);
`else
        d_win       = d_req;
`endif
        g_addr      = d_win ? d_addr : i_addr;

        // recv_avail is still high in the cycle our ack is on the wire; the
        // pop only takes effect at the next edge, so ignore it then.
        resp_ok  = recv_avail & ~recv_ack;
        // Requests are still held in the done cycle; starting a transfer then
        // would re-issue the completed one.
        grant_ok = ~i_done & ~d_done;

        unique case (state)
            ST_IDLE: begin
                if (resp_ok) begin
                    recv_ack_n = 1'b1;
                    err_n      = 1'b1;
                end
                if (grant_ok && (i_req || d_req)) begin
                    cur_d_n  = d_win;
                    cur_we_n = d_win & d_we;
                    if (d_win && d_we) begin
                        send_len_n  = 5'd9;
                        send_data_n = {4'b0, d_mask, d_addr, d_wdata};
                    end else begin
                        send_len_n  = 5'd5;
                        send_data_n = {40'b0, g_addr};
                    end
                    state_n = ST_SEND;
                end
            end

            ST_SEND: begin
                if (send_ready) begin
                    send_flag_n = 1'b1;
                    if (cur_we) begin
                        d_done_n = 1'b1;
                        state_n  = ST_IDLE;
`ifdef MEM_ARB_RR_EN
                        ptr_d_n  = ~cur_d;
`endif
                    end else begin
                        cnt_n   = '0;
                        state_n = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                cnt_n = cnt + 1'b1;
                if (resp_ok) begin
                    recv_ack_n = 1'b1;
                    if (recv_len == 5'd4) begin
                        rd_finish = 1'b1;
                        rd_val    = recv_data[31:0];
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (TIMEOUT != 0 && cnt == TO_BITS'(TIMEOUT - 1)) begin
                    rd_finish = 1'b1;
                    err_n     = 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        if (rd_finish) begin
            state_n = ST_IDLE;
            if (cur_d) begin
                d_done_n  = 1'b1;
                d_rdata_n = rd_val;
            end else begin
                i_done_n  = 1'b1;
                i_rdata_n = rd_val;
            end
`ifdef MEM_ARB_RR_EN
            ptr_d_n = ~cur_d;
`endif
        end
    end

endmodule
